// File: rtl/wb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_regfile : write-back stage register file with bypassed read ports,
//              registered commit trace and commit counter.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module wb_regfile #(
   parameter int DSIZE    = 32,
   parameter int ASIZE    = 5,
   parameter int ISIZE    = 32,
   parameter int LINK_REG = 31,
   parameter int CSIZE    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen_in,
   input  logic             mem_to_reg_in,
   input  logic [DSIZE-1:0] result_in,
   input  logic [DSIZE-1:0] rdata_mem_in,
   input  logic [ASIZE-1:0] waddr_in,
   input  logic             jal_in,
   input  logic [ISIZE-1:0] PC_jal_in,
   input  logic [ASIZE-1:0] raddr1,
   input  logic [ASIZE-1:0] raddr2,
   output logic [DSIZE-1:0] rdata1,
   output logic [DSIZE-1:0] rdata2,
   output logic             trace_valid,
   output logic [ASIZE-1:0] trace_addr,
   output logic [DSIZE-1:0] trace_data,
   output logic [CSIZE-1:0] wb_count
);

   localparam int NREGS = 1 << ASIZE;

   logic [DSIZE-1:0] regs_q [NREGS];
   logic [DSIZE-1:0] regs_d [NREGS];
   logic             trace_valid_q, trace_valid_d;
   logic [ASIZE-1:0] trace_addr_q, trace_addr_d;
   logic [DSIZE-1:0] trace_data_q, trace_data_d;
   logic [CSIZE-1:0] wb_count_q, wb_count_d;

   logic [ASIZE-1:0] waddr_eff;
   logic [DSIZE-1:0] wdata_eff;
   logic [DSIZE-1:0] pc_ext;
   logic             commit;

   generate
      if (ISIZE >= DSIZE) begin : g_pc_trunc
         assign pc_ext = PC_jal_in[DSIZE-1:0];
      end else begin : g_pc_zext
         assign pc_ext = {{(DSIZE-ISIZE){1'b0}}, PC_jal_in};
      end
   endgenerate

   // rst_n gates commit so neither the array nor the bypass can change in reset
   always_comb begin
      waddr_eff = jal_in ? ASIZE'(LINK_REG) : waddr_in;
      if (jal_in)
         wdata_eff = pc_ext;
      else if (mem_to_reg_in)
         wdata_eff = rdata_mem_in;
      else
         wdata_eff = result_in;
      commit = rst_n & (wen_in | jal_in) & (waddr_eff != '0);
   end

   always_comb begin
      if (raddr1 == '0)
         rdata1 = '0;
      else if (commit && (raddr1 == waddr_eff))
         rdata1 = wdata_eff;
      else
         rdata1 = regs_q[raddr1];
   end

   always_comb begin
      if (raddr2 == '0)
         rdata2 = '0;
      else if (commit && (raddr2 == waddr_eff))
         rdata2 = wdata_eff;
      else
         rdata2 = regs_q[raddr2];
   end

   always_comb begin
      regs_d        = regs_q;
      trace_valid_d = commit;
      trace_addr_d  = trace_addr_q;
      trace_data_d  = trace_data_q;
      wb_count_d    = wb_count_q;
      if (commit) begin
         regs_d[waddr_eff] = wdata_eff;
         trace_addr_d      = waddr_eff;
         trace_data_d      = wdata_eff;
         wb_count_d        = wb_count_q + CSIZE'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs_q[i] <= '0;
         trace_valid_q <= 1'b0;
         trace_addr_q  <= '0;
         trace_data_q  <= '0;
         wb_count_q    <= '0;
      end else begin
         regs_q        <= regs_d;
         trace_valid_q <= trace_valid_d;
         trace_addr_q  <= trace_addr_d;
         trace_data_q  <= trace_data_d;
         wb_count_q    <= wb_count_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_addr  = trace_addr_q;
   assign trace_data  = trace_data_q;
   assign wb_count    = wb_count_q;

endmodule
`default_nettype wire
